iob2axi_rd_burst: RTL and testbench
===================================

// Module: iob2axi_rd_burst
// PURPOSE
//  AXI4 read master that moves an arbitrary-length transfer into the native (IOb) write port.
//  Splits the transfer into INCR bursts of at most MAX_BURST_LEN beats; no burst crosses a 4 KB boundary.
//  Native write data leaves through a registered output stage with backpressure.
//  Sits between DMA/control logic and the AXI interconnect; replaces the single-burst read bridge.
// PARAMETERS
//  ADDR_W        32  native and AXI byte-address width
//  DATA_W        32  data width; power of two, >= 8
//  LEN_W         16  transfer length width, in words
//  MAX_BURST_LEN 16  max beats per burst; 1..256
// PORTS
//  clk            in   1         clock; all logic on posedge
//  rst_n          in   1         reset, asynchronous, active-low
//  run            in   1         start pulse; sampled only while ready=1
//  addr           in   ADDR_W    start byte address; low log2(DATA_W/8) bits are forced to 0
//  length         in   LEN_W     transfer length in words; 0 = no-op
//  ready          out  1         idle, accepts run
//  error          out  1         sticky error flag for the last transfer
//  m_valid        out  1         native write valid
//  m_addr         out  ADDR_W    byte address of the word on m_wdata
//  m_wdata        out  DATA_W    read data
//  m_wstrb        out  DATA_W/8  all ones
//  m_ready        in   1         native write accepted
//  m_axi_ar*/r*   AXI4 read-channel ports, as in axi.vh
//    arid=0, arsize=log2(DATA_W/8), arburst=INCR, arlock=0, arcache=2, arprot=2, arqos=0
// BEHAVIOUR
//  Reset values: ready=1, error=0, m_valid=0, m_axi_arvalid=0, m_axi_rready=0, all counters 0. State=IDLE.
//  Reset asserted mid-transfer aborts immediately. No AXI cleanup is done (system-level reset is assumed).
//  FSM states: IDLE -> ADDR -> DATA -> (ADDR | IDLE).
//  IDLE: ready=1.
//    - run with length!=0: latch addr and length; error<=0; ready<=0; go to ADDR on the next cycle.
//    - run with length==0: error<=0; stay in IDLE.
//  ADDR: arvalid=1, stable until arready.
//    - arlen = min(MAX_BURST_LEN, remaining, words_to_4k) - 1.
//    - words_to_4k = (4096 - cur_addr[11:0]) >> log2(DATA_W/8).
//    - On arvalid&arready: go to DATA with beat counter = 0.
//  DATA: rready = ~m_valid | m_ready (single output register).
//    - Each r handshake loads m_wdata=rdata and m_addr=cur_addr; m_valid<=1 next cycle; cur_addr += DATA_W/8.
//    - Latency from r handshake to m_valid: 1 cycle. Holds with m_ready=1: one beat per cycle.
//    - error |= (rresp!=0) on any beat.
//    - error |= rlast on a non-final beat, or ~rlast on the final beat. Beat count is authoritative; the early rlast is ignored.
//  End of burst (beat count == arlen): remaining -= arlen+1.
//    - remaining!=0: go to ADDR.
//    - remaining==0: go to IDLE; ready=1 only after the output register drains (m_valid=0).
//  m_valid&~m_ready holds m_wdata/m_addr stable; rready=0 blocks further beats.
//  Arithmetic: remaining is LEN_W bits; cur_addr wraps modulo 2^ADDR_W; burst length is computed in 9 bits.
//  run while ready=0 is ignored.
// CONFIGURATION
//  IOB2AXI_RD_ABORT_EN defined:
//    - On the first error, no further AR is issued.
//    - The current burst is drained: rready stays 1, and m_valid is suppressed for remaining beats.
//    - The FSM then returns to IDLE.
//  Not defined: every burst is issued, all beats are forwarded, and error is only flagged.
// STRUCTURE
//  axi.vh: AXI_LEN_W, AXI_ID_W, burst/size/cache/prot constants, and the port macro.
//    Local state encodings stay in localparams.
//  Sub-module iob2axi_burst_calc (combinational): inputs cur_addr and remaining; output next arlen.
//    Contains the min() and 4 KB logic.
//  Top level holds the FSM, counters and output register.
// TESTING
//  1) addr=0x100, length=4, MAX=16, m_ready=1:
//     one AR with arlen=3; m_addr 0x100..0x10C; ready back 1 cycle after the last m_valid; error=0.
//  2) addr=0x0, length=40, MAX=16:
//     three ARs: arlen 15,15,7 at 0x0, 0x40, 0x80; 40 writes in order.
//  3) addr=0xFF8, length=8 (DATA_W=32):
//     ARs with arlen=1 @0xFF8 and arlen=5 @0x1000; no 4 KB crossing.
//  4) m_ready toggling every 2 cycles with rvalid continuous:
//     no data lost or duplicated; rready low exactly while m_valid&~m_ready.
//  5) rresp=SLVERR on beat 2 of 4, then rlast missing on the final beat:
//     error=1 at the return to IDLE; error=0 after the next run.
//     With ABORT_EN and length=32: a single AR only.
//  6) length=0: no AR, ready stays 1.
//     rst_n low mid-DATA: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/iob2axi_rd_burst_pkg.sv
// Shared AXI4 read-channel constants and FSM state encoding for iob2axi_rd_burst.
package iob2axi_rd_burst_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_ID_W    = 1;
    localparam int BOUNDARY_4K = 4096;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_CACHE_MODIF = 4'b0010;
    localparam logic [2:0] AXI_PROT_NS     = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

endpackage

// File: rtl/iob2axi_burst_calc.sv
// Combinational burst sizing: the largest INCR burst that fits the remaining words,
// the MAX_BURST_LEN limit and the distance to the next 4 KB boundary.
module iob2axi_burst_calc
    import iob2axi_rd_burst_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int LEN_W         = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [ADDR_W-1:0]    cur_addr,
    input  logic [LEN_W-1:0]     remaining,
    output logic [AXI_LEN_W-1:0] arlen
);

    localparam int SZ = $clog2(DATA_W / 8);
    localparam int CW = (LEN_W > 13) ? LEN_W : 13;

    logic [12:0]   bytes_to_4k;
    logic [CW-1:0] words_to_4k;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] blen;
    logic [8:0]    blen9;
    logic          unused_high_addr;

    assign unused_high_addr = ^cur_addr[ADDR_W-1:12];

    // 13 bits so an aligned address yields the full 4096 bytes rather than 0.
    assign bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, cur_addr[11:0]};
    assign words_to_4k = CW'(bytes_to_4k >> SZ);
    assign rem_w       = CW'(remaining);

    always_comb begin
        blen = CW'(MAX_BURST_LEN);
        if (rem_w < blen)       blen = rem_w;
        if (words_to_4k < blen) blen = words_to_4k;
    end

    assign blen9 = 9'(blen);
    assign arlen = AXI_LEN_W'(blen9 - 9'd1);

endmodule

// File: rtl/iob2axi_rd_burst.sv
// AXI4 read master that streams an arbitrary-length transfer into the native write port.
// Define IOB2AXI_RD_ABORT_EN to stop issuing bursts after the first read error.
module iob2axi_rd_burst
    import iob2axi_rd_burst_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int LEN_W         = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [LEN_W-1:0]      length,
    output logic                  ready,
    output logic                  error,
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_ready,
    output logic [AXI_ID_W-1:0]   m_axi_arid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [AXI_LEN_W-1:0]  m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [AXI_ID_W-1:0]   m_axi_rid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int                BYTES     = DATA_W / 8;
    localparam int                SZ        = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BYTES - 1);
`ifdef IOB2AXI_RD_ABORT_EN
    localparam logic ABORT_EN = 1'b1;
`else
    localparam logic ABORT_EN = 1'b0;
`endif

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     cur_addr;
    logic [LEN_W-1:0]      remaining, remaining_nxt;
    logic [AXI_LEN_W-1:0]  arlen_calc, arlen_q, beat_cnt;
    logic                  drain, r_hs, last_beat, beat_err, unused_rid;

    iob2axi_burst_calc #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .LEN_W         (LEN_W),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .cur_addr  (cur_addr),
        .remaining (remaining),
        .arlen     (arlen_calc)
    );

    // After an error in abort mode the burst is drained: accept beats without forwarding them.
    assign drain         = ABORT_EN & error;
    assign m_axi_rready  = (state == ST_DATA) && (drain || !m_valid || m_ready);
    assign r_hs          = m_axi_rvalid && m_axi_rready;
    assign last_beat     = (beat_cnt == arlen_q);
    assign beat_err      = (m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat);
    assign remaining_nxt = remaining - (LEN_W'(arlen_q) + LEN_W'(1));
    assign unused_rid    = ^m_axi_rid;

    assign m_wstrb       = '1;
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = cur_addr;
    assign m_axi_arlen   = arlen_calc;
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE_MODIF;
    assign m_axi_arprot  = AXI_PROT_NS;
    assign m_axi_arqos   = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        ready         = 1'b0;
        m_axi_arvalid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ready = !m_valid;
                if (run && !m_valid && (length != '0)) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (r_hs && last_beat) begin
                    if ((remaining_nxt == '0) || (ABORT_EN && (error || beat_err)))
                        state_nxt = ST_IDLE;
                    else
                        state_nxt = ST_ADDR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the output data register is reset along with the control state so m_addr/m_wdata are never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            arlen_q   <= '0;
            beat_cnt  <= '0;
            error     <= 1'b0;
            m_valid   <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
        end else begin
            if (m_valid && m_ready) m_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run && ready) begin
                        error <= 1'b0;
                        if (length != '0) begin
                            cur_addr  <= addr & WORD_MASK;
                            remaining <= length;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        arlen_q  <= arlen_calc;
                        beat_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        if (!drain) begin
                            m_valid <= 1'b1;
                            m_wdata <= m_axi_rdata;
                            m_addr  <= cur_addr;
                        end
                        cur_addr <= cur_addr + ADDR_W'(BYTES);
                        error    <= error | beat_err;
                        beat_cnt <= beat_cnt + AXI_LEN_W'(1);
                        if (last_beat) remaining <= remaining_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob2axi_rd_burst.sv
// Self-checking bench for iob2axi_rd_burst: AXI read slave model, transfer-level reference model
// and a per-cycle compare process on the native write port.
`timescale 1ns/1ps
module tb_iob2axi_rd_burst;
    import iob2axi_rd_burst_pkg::*;

`ifdef IOB2AXI_RD_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] length = '0;
    logic        ready, error, m_valid;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready = 1'b1;
    logic [0:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache, m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [0:0]  m_axi_rid = '0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    iob2axi_rd_burst dut (
        .clk(clk), .rst_n(rst_n), .run(run), .addr(addr), .length(length),
        .ready(ready), .error(error), .m_valid(m_valid), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; int len; } ar_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

    ar_t bq[$];
    ar_t ar_log[$];
    ar_t exp_ars[$];
    wr_t exp_wr[$];

    int checks = 0, failures = 0;
    int sbeat = 0, gbeat = 0, tot_beats = 0, inj_err_beat = -1;
    bit inj_nolast = 1'b0;
    int mr_mode = 0;
    bit ar_slow = 1'b0;
    int cyc = 0, last_wr_cyc = 0, rise_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Reference: split the transfer into bursts by plain arithmetic and list every expected write.
    task automatic build_model(input logic [31:0] a0, input int n, input int eb);
        logic [31:0] a;
        int rem, beats, off, to4k, nb;
        bit cut;
        exp_ars.delete();
        exp_wr.delete();
        a = a0 & ~32'h3;
        rem = n;
        beats = 0;
        cut = 1'b0;
        while (rem > 0 && !cut) begin
            off  = int'(a & 32'hFFF);
            to4k = (4096 - off) / 4;
            nb   = 16;
            if (rem < nb)  nb = rem;
            if (to4k < nb) nb = to4k;
            exp_ars.push_back('{a, nb - 1});
            for (int i = 0; i < nb; i++) begin
                if (!ABORT || eb < 0 || beats <= eb)
                    exp_wr.push_back('{a + 32'(4 * i), mem_data(a + 32'(4 * i))});
                beats++;
            end
            if (ABORT && eb >= 0 && beats > eb) cut = 1'b1;
            a   = a + 32'(4 * nb);
            rem = rem - nb;
        end
    endtask

    // AXI read slave: presents inputs on the falling edge, observes handshakes just before the rising edge.
    initial begin : slave
        int dcyc;
        dcyc = 0;
        forever begin
            @(negedge clk);
            m_ready = (mr_mode == 0) ? 1'b1 : (((dcyc / 2) % 2) == 0);
            m_axi_arready = ar_slow ? ((dcyc % 3) == 2) : 1'b1;
            if (bq.size() > 0) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = mem_data(bq[0].a + 32'(4 * sbeat));
                m_axi_rresp  = (gbeat == inj_err_beat) ? 2'b10 : 2'b00;
                m_axi_rlast  = (sbeat == bq[0].len) && !(inj_nolast && gbeat == tot_beats - 1);
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rdata  = '0;
                m_axi_rresp  = 2'b00;
                m_axi_rlast  = 1'b0;
            end
            #1;
            if (rst_n) begin
                if (m_axi_rvalid && m_axi_rready) begin
                    gbeat++;
                    if (sbeat == bq[0].len) begin
                        void'(bq.pop_front());
                        sbeat = 0;
                    end else begin
                        sbeat++;
                    end
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    bq.push_back('{m_axi_araddr, int'(m_axi_arlen)});
                    ar_log.push_back('{m_axi_araddr, int'(m_axi_arlen)});
                end
            end
            dcyc++;
        end
    end

    // Compare process: checks the native port and AR/R channel rules every cycle.
    initial begin : monitor
        logic        prev_ready, prev_stall, prev_arv, prev_arr;
        logic [31:0] held_a, held_d, prev_araddr;
        logic [7:0]  prev_arlen;
        wr_t         w;
        prev_ready = 1'b1; prev_stall = 1'b0; prev_arv = 1'b0; prev_arr = 1'b0;
        held_a = '0; held_d = '0; prev_araddr = '0; prev_arlen = '0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst_n) begin
                if (m_valid) check("m_wstrb", m_wstrb, 4'hF);
                check("ready_while_valid", ready && m_valid, 0);
                if (m_valid && m_ready) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got addr 0x%0h, expected none", m_addr);
                    end else begin
                        w = exp_wr.pop_front();
                        check("m_addr", m_addr, w.a);
                        check("m_wdata", m_wdata, w.d);
                    end
                    last_wr_cyc = cyc;
                end
                if (prev_stall && m_valid) begin
                    check("hold_addr", m_addr, held_a);
                    check("hold_data", m_wdata, held_d);
                end
                if (m_axi_rvalid && !(ABORT && error))
                    check("rready_rule", m_axi_rready, !(m_valid && !m_ready));
                if (prev_arv && !prev_arr)
                    check("ar_stable", {m_axi_arvalid, m_axi_araddr, m_axi_arlen},
                          {1'b1, prev_araddr, prev_arlen});
                if (m_axi_arvalid)
                    check("ar_fields", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                                        m_axi_arcache, m_axi_arprot, m_axi_arqos},
                          {1'b0, 3'd2, 2'b01, 1'b0, 4'd2, 3'd2, 4'd0});
                if (ready && !prev_ready) rise_cyc = cyc;
            end
            prev_ready  = ready;
            prev_stall  = m_valid && !m_ready;
            held_a      = m_addr;
            held_d      = m_wdata;
            prev_arv    = m_axi_arvalid;
            prev_arr    = m_axi_arready;
            prev_araddr = m_axi_araddr;
            prev_arlen  = m_axi_arlen;
        end
    end

    task automatic check_ar(input int i, input logic [31:0] a, input int len);
        if (i < ar_log.size()) begin
            check($sformatf("lit_ar%0d_addr", i), ar_log[i].a, a);
            check($sformatf("lit_ar%0d_len", i), ar_log[i].len, len);
        end else begin
            checks++;
            failures++;
            $display("FAIL lit_ar%0d: got no AR, expected addr 0x%0h len %0d", i, a, len);
        end
    endtask

    task automatic start_xfer(input logic [31:0] a, input int n, input int eb, input bit nl);
        inj_err_beat = eb;
        inj_nolast   = nl;
        tot_beats    = n;
        gbeat        = 0;
        build_model(a, n, eb);
        ar_log.delete();
        @(negedge clk);
        run    = 1'b1;
        addr   = a;
        length = 16'(n);
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] a, input int n, input int eb, input bit nl, input bit exp_err);
        int cnt;
        start_xfer(a, n, eb, nl);
        cnt = 0;
        while (!(ready && exp_wr.size() == 0) && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 3000) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout: got no completion, expected ready within 3000 cycles");
        end
        if (n == 0) begin
            repeat (4) begin
                @(negedge clk);
                #3;
                check("noop_ready", ready, 1);
            end
        end
        #3;
        check("error", error, exp_err);
        check("ar_count", ar_log.size(), exp_ars.size());
        for (int i = 0; i < ar_log.size() && i < exp_ars.size(); i++) begin
            check("ar_addr", ar_log[i].a, exp_ars[i].a);
            check("ar_len", ar_log[i].len, exp_ars[i].len);
        end
        check("writes_left", exp_wr.size(), 0);
    endtask

    initial begin : main
        int cnt;
        repeat (3) @(negedge clk);
        #3;
        check("reset_state", {ready, error, m_valid, m_axi_arvalid, m_axi_rready}, 5'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single short burst
        xfer(32'h100, 4, -1, 1'b0, 1'b0);
        check_ar(0, 32'h100, 3);
        check("ready_after_last", rise_cyc, last_wr_cyc + 1);

        // MAX_BURST_LEN splitting with a slow AR slave
        ar_slow = 1'b1;
        xfer(32'h0, 40, -1, 1'b0, 1'b0);
        check_ar(0, 32'h0, 15);
        check_ar(1, 32'h40, 15);
        check_ar(2, 32'h80, 7);
        ar_slow = 1'b0;

        // 4 KB boundary
        xfer(32'hFF8, 8, -1, 1'b0, 1'b0);
        check_ar(0, 32'hFF8, 1);
        check_ar(1, 32'h1000, 5);

        // native backpressure, boundary-limited first burst
        mr_mode = 1;
        xfer(32'h3FC4, 50, -1, 1'b0, 1'b0);
        check_ar(0, 32'h3FC4, 14);
        mr_mode = 0;

        // SLVERR on beat 2 plus missing rlast on the final beat
        xfer(32'h500, 4, 2, 1'b1, 1'b1);

        // zero-length run clears error and issues nothing
        xfer(32'h0, 0, -1, 1'b0, 1'b0);

        // error in the first burst of a two-burst transfer
        xfer(32'h600, 32, 2, 1'b0, 1'b1);
        check("abort_ar_count", ar_log.size(), ABORT ? 1 : 2);

        // asynchronous reset mid-DATA
        start_xfer(32'h800, 40, 0, 1'b0);
        cnt = 0;
        while (!m_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_pre_valid", m_valid, 1);
        @(negedge clk);
        #3;
        check("rst_pre_error", error, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {ready, error, m_valid, m_axi_arvalid, m_axi_rready}, 5'b10000);
        bq.delete();
        sbeat = 0;
        exp_wr.delete();
        inj_err_beat = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // recovery with an unaligned start address
        xfer(32'h102, 4, -1, 1'b0, 1'b0);
        check_ar(0, 32'h100, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
